// File: rtl/scene_compositor.sv
// scene_compositor: once per frame, snapshots the draw list for the active
// screen into a shadow buffer and streams it one object per valid/ready beat.
module scene_compositor #(
  parameter int unsigned N_OBJ      = 6,
  parameter int unsigned ID_W       = 5,
  parameter int unsigned POS_W      = 17,
  parameter int unsigned XOFF_W     = 9,
  parameter int unsigned LANE_BASE  = 64,
  parameter int unsigned LANE_PITCH = 48,
  parameter int unsigned HIT_BAR_ID = 4,
  parameter int unsigned SKIP_ZERO  = 1
) (
  input  logic                        CLOCK_50,
  input  logic                        reset_b,
  input  logic [1:0]                  screen,
  input  logic                        frame_start,
  input  logic [ID_W-1:0]             title_id,
  input  logic [N_OBJ*ID_W-1:0]       menu_ids,
  input  logic [N_OBJ*POS_W-1:0]      menu_pos,
  input  logic [(N_OBJ-1)*ID_W-1:0]   game_ids,
  input  logic [XOFF_W-1:0]           xoffset,
  output logic                        obj_valid,
  input  logic                        obj_ready,
  output logic [$clog2(N_OBJ)-1:0]    obj_index,
  output logic [ID_W-1:0]             obj_id,
  output logic [POS_W-1:0]            obj_pos,
  output logic                        obj_last,
  output logic                        frame_busy,
  output logic                        overrun
);

  localparam int unsigned IDX_W = $clog2(N_OBJ);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EMPTY,
    ST_STREAM
  } state_t;

  state_t             state;
  logic [ID_W-1:0]    snap_id    [N_OBJ];
  logic [POS_W-1:0]   snap_pos   [N_OBJ];
  logic [ID_W-1:0]    shadow_id  [N_OBJ];
  logic [POS_W-1:0]   shadow_pos [N_OBJ];
  logic [IDX_W-1:0]   last_idx;
  logic               snap_any;
  logic [IDX_W-1:0]   snap_first;
  logic [IDX_W-1:0]   snap_last;
  logic [IDX_W-1:0]   nxt_idx;
  logic               last_accept;
  logic               start_go;

  // Live draw list for the selected screen, as it would be latched this edge.
  always_comb begin
    for (int k = 0; k < int'(N_OBJ); k++) begin
      snap_id[k]  = '0;
      snap_pos[k] = '0;
    end
    case (screen)
      2'd0: begin
        for (int k = 0; k < int'(N_OBJ); k++) snap_id[k] = title_id;
      end
      2'd1: begin
        for (int k = 0; k < int'(N_OBJ); k++) begin
          snap_id[k]  = menu_ids[k*ID_W +: ID_W];
          snap_pos[k] = menu_pos[k*POS_W +: POS_W];
        end
      end
      2'd2: begin
        snap_id[0] = ID_W'(HIT_BAR_ID);
        for (int j = 0; j < int'(N_OBJ) - 1; j++) begin
          snap_id[j+1]  = game_ids[j*ID_W +: ID_W];
          snap_pos[j+1] = POS_W'(LANE_BASE + 32'(j) * LANE_PITCH) + POS_W'(xoffset);
        end
      end
      default: ;
    endcase
  end

  // First/last emitted slot of the incoming list, and next emitted slot of the shadow.
  always_comb begin
    snap_any   = 1'b0;
    snap_first = '0;
    snap_last  = '0;
    nxt_idx    = obj_index;
    for (int k = int'(N_OBJ) - 1; k >= 0; k--) begin
      if (SKIP_ZERO == 0 || snap_id[k] != '0) begin
        snap_any   = 1'b1;
        snap_first = IDX_W'(k);
      end
      if ((IDX_W'(k) > obj_index) && (SKIP_ZERO == 0 || shadow_id[k] != '0)) begin
        nxt_idx = IDX_W'(k);
      end
    end
    for (int k = 0; k < int'(N_OBJ); k++) begin
      if (SKIP_ZERO == 0 || snap_id[k] != '0) snap_last = IDX_W'(k);
    end
  end

  // A new frame may begin when idle or exactly as the final beat is accepted.
  always_comb begin
    last_accept = (state == ST_STREAM) && obj_valid && obj_ready && obj_last;
    start_go    = frame_start && ((state == ST_IDLE) || last_accept);
  end

  // Frame FSM: snapshot, stream, overrun tracking; all outputs registered.
  always_ff @(posedge CLOCK_50 or negedge reset_b) begin
    if (!reset_b) begin
      state      <= ST_IDLE;
      obj_valid  <= 1'b0;
      obj_index  <= '0;
      obj_id     <= '0;
      obj_pos    <= '0;
      obj_last   <= 1'b0;
      frame_busy <= 1'b0;
      overrun    <= 1'b0;
      last_idx   <= '0;
      for (int k = 0; k < int'(N_OBJ); k++) begin
        shadow_id[k]  <= '0;
        shadow_pos[k] <= '0;
      end
    end else begin
      if (frame_start && frame_busy && !start_go) overrun <= 1'b1;
      if (start_go) begin
        for (int k = 0; k < int'(N_OBJ); k++) begin
          shadow_id[k]  <= snap_id[k];
          shadow_pos[k] <= snap_pos[k];
        end
        last_idx   <= snap_last;
        frame_busy <= 1'b1;
        if (snap_any) begin
          state     <= ST_STREAM;
          obj_valid <= 1'b1;
          obj_index <= snap_first;
          obj_id    <= snap_id[snap_first];
          obj_pos   <= snap_pos[snap_first];
          obj_last  <= (snap_first == snap_last);
        end else begin
          state     <= ST_EMPTY;
          obj_valid <= 1'b0;
          obj_last  <= 1'b0;
        end
      end else begin
        case (state)
          ST_EMPTY: begin
            state      <= ST_IDLE;
            frame_busy <= 1'b0;
          end
          ST_STREAM: begin
            if (obj_valid && obj_ready) begin
              if (obj_last) begin
                state      <= ST_IDLE;
                obj_valid  <= 1'b0;
                obj_last   <= 1'b0;
                frame_busy <= 1'b0;
              end else begin
                obj_index <= nxt_idx;
                obj_id    <= shadow_id[nxt_idx];
                obj_pos   <= shadow_pos[nxt_idx];
                obj_last  <= (nxt_idx == last_idx);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/scene_compositor.md
# scene_compositor

Parametrised, frame-synchronous draw-list builder between the screen/play logic and the graphics engine. Once per video frame it snapshots the draw list for the active screen (title, menu, game or blank) into a shadow buffer, so the list cannot tear mid-frame. It then streams the objects one per beat over a valid/ready handshake, optionally skipping empty (id 0) slots. It generalises the fixed 6-object combinational screen mux to N objects with registered, back-pressured delivery and overrun detection.

## Interface
- N_OBJ, 6: object slots per frame (≥2); slot 0 is the hit bar in game mode.
- ID_W, 5: sprite id width.
- POS_W, 17: position word width.
- XOFF_W, 9: scroll offset width.
- LANE_BASE, 64: game-mode position of slot 1 before offset.
- LANE_PITCH, 48: game-mode spacing between consecutive lanes.
- HIT_BAR_ID, 4: sprite id placed in slot 0 in game mode.
- SKIP_ZERO, 1: when 1, slots with id 0 are not emitted.

Ports:
- CLOCK_50  in  1  system clock; all logic on the rising edge.
- reset_b  in  1  asynchronous, active-low reset.
- screen  in  2  0 = title, 1 = menu, 2 = game, 3 = blank.
- frame_start  in  1  one-cycle pulse per video frame.
- title_id  in  ID_W  id used for every slot on the title screen.
- menu_ids  in  N_OBJ*ID_W  menu ids; slot k at [k*ID_W +: ID_W].
- menu_pos  in  N_OBJ*POS_W  menu positions; slot k at [k*POS_W +: POS_W].
- game_ids  in  (N_OBJ-1)*ID_W  game lane ids; lane j feeds slot j+1.
- xoffset  in  XOFF_W  game scroll offset.
- obj_valid  out  1  beat valid.
- obj_ready  in  1  consumer accepts the beat when high with obj_valid.
- obj_index  out  clog2(N_OBJ)  slot number of the current beat.
- obj_id  out  ID_W  sprite id.
- obj_pos  out  POS_W  sprite position.
- obj_last  out  1  final beat of the frame.
- frame_busy  out  1  high while a frame is streaming.
- overrun  out  1  sticky: a frame_start arrived while busy.

## Operation
- Slot contents by screen:
  - Title: id = title_id, pos = 0 for every slot.
  - Menu: menu_ids/menu_pos passed through unchanged.
  - Game: slot 0 = (HIT_BAR_ID, 0); slot k≥1 = (game_ids lane k-1, LANE_BASE + (k-1)*LANE_PITCH + xoffset). The sum is computed zero-extended at POS_W bits and wraps modulo 2^POS_W.
  - Blank: all ids 0, all positions 0.
- States:
  - IDLE → SNAP on frame_start. All N_OBJ id/pos pairs are latched into the shadow buffer on that edge; inputs are don't-care after the latch.
  - STREAM walks the slots in ascending order.
  - With SKIP_ZERO = 1, id-0 slots are skipped with no beat and no dead cycle. obj_last marks the highest-index nonzero slot.
  - If every slot is zero, no beat is emitted; the FSM returns to IDLE the cycle after the snapshot and frame_busy pulses for 1 cycle.
  - With SKIP_ZERO = 0, exactly N_OBJ beats are emitted and obj_last marks slot N_OBJ-1.
  - After the obj_last beat is accepted, the FSM returns to IDLE.
- Back-to-back frames: frame_start in the same cycle as acceptance of the obj_last beat is legal. It snapshots and restarts with no idle cycle and does not set overrun.
- Overrun: frame_start while busy (other than the back-to-back case) is ignored. The stream continues, overrun is set, and it clears only on reset.
- Screen changes between frames take effect at the next frame_start only.

## Timing
- Reset values: obj_valid 0, obj_index 0, obj_id 0, obj_pos 0, obj_last 0, frame_busy 0, overrun 0. The shadow buffer clears to 0 and the FSM is in IDLE.
- Reset asserted mid-frame drops obj_valid immediately (asynchronously) and abandons the frame; no partial resume.
- Latency: first obj_valid appears 1 cycle after the frame_start cycle. frame_busy rises in that same cycle and falls in the cycle after the obj_last acceptance.
- Handshake:
  - While obj_valid = 1 and obj_ready = 0, all obj_* outputs hold stable.
  - A beat transfers on a rising edge where both are high.
  - obj_valid never drops without a transfer, except on reset.
- Throughput: one beat per cycle with obj_ready held high. A full N_OBJ frame occupies N_OBJ cycles of frame_busy.
- All outputs are registered; there is no combinational path from obj_ready to obj_valid.

## Test plan
- Reset, then game screen, defaults, SKIP_ZERO = 0, xoffset = 10, game_ids = 1,2,3,4,5, ready high, frame_start -> 6 beats on consecutive cycles. Ids 4,1,2,3,4,5; positions 0,74,122,170,218,266; obj_last only on index 5.
- Menu screen with slots 2 and 5 id 0, SKIP_ZERO = 1 -> beats for indices 0,1,3,4 only; obj_last on index 4; frame_busy high for 4 cycles.
- obj_ready toggled 1,0,0,1 during game frame -> outputs frozen during stall; no beat lost or duplicated; total 6 transfers.
- frame_start pulsed on beat 3 of a frame -> frame completes unaltered and overrun = 1. Then frame_start on the obj_last acceptance cycle -> next frame starts the following cycle with overrun unchanged.
- Game mode, xoffset = 511, POS_W = 9 override -> slot 1 position = (64+511) mod 512 = 63.
- Blank screen with SKIP_ZERO = 1 -> zero beats, one-cycle frame_busy pulse. reset_b low mid-stream -> obj_valid 0 the same cycle and all outputs at reset values.
